mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_access_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned MASK_W = XLEN / 8;

    logic              dmem_read;
    logic              dmem_write;
    logic [XLEN-1:0]   dmem_addr;
    logic [MASK_W-1:0] dmem_wmask;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN-1:0]   dmem_rdata;
    logic              dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_addr, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_addr, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: issues data-memory accesses, stalls until dmem_resp, formats loads into MEM/WB.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are not issued and flag wb_misalign.
module mem_access_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_load,
    input  logic                ex_store,
    input  logic                ex_reg_we,
    input  logic [2:0]          ex_funct3,
    input  logic [4:0]          ex_rd,
    input  logic [XLEN-1:0]     ex_alu_out,
    input  logic [XLEN-1:0]     ex_rs2_data,
    mem_access_stage_if.master  dmem,
    output logic                mem_stall,
    output logic                wb_valid,
    output logic                wb_reg_we,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                wb_misalign
);
    localparam int unsigned MASK_W = XLEN / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   req_addr_q;
    logic [MASK_W-1:0] req_wmask_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [2:0]        req_funct3_q;
    logic [4:0]        req_rd_q;
    logic              req_reg_we_q;
    logic              req_load_q;

    logic              is_mem_c;
    logic              misalign_c;
    logic              issue_c;
    logic [MASK_W-1:0] st_wmask_c;
    logic [XLEN-1:0]   st_wdata_c;
    logic [7:0]        ld_byte_c;
    logic [15:0]       ld_half_c;
    logic [XLEN-1:0]   ld_data_c;
    logic              wb_valid_d, wb_reg_we_d, wb_misalign_d;
    logic [4:0]        wb_rd_d;
    logic [XLEN-1:0]   wb_data_d;

    assign is_mem_c = ex_load | ex_store;

`ifdef MEM_MISALIGN_TRAP_EN
    // Half needs a[0]==0, word needs a[1:0]==0; a load+store combo is judged as a load.
    always_comb begin : misalign_check
        misalign_c = 1'b0;
        if (is_mem_c) begin
            if (ex_funct3 == 3'b001 || (ex_load && ex_funct3 == 3'b101))
                misalign_c = ex_alu_out[0];
            else if (ex_funct3 == 3'b010)
                misalign_c = |ex_alu_out[1:0];
        end
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Store lane placement; loads never write any byte.
    always_comb begin : store_lanes
        st_wmask_c = '0;
        st_wdata_c = ex_rs2_data;
        if (!ex_load) begin
            case (ex_funct3)
                3'b000: begin
                    st_wmask_c = MASK_W'(1) << ex_alu_out[1:0];
                    st_wdata_c = {4{ex_rs2_data[7:0]}};
                end
                3'b001: begin
                    st_wmask_c = MASK_W'(3) << {ex_alu_out[1], 1'b0};
                    st_wdata_c = {2{ex_rs2_data[15:0]}};
                end
                3'b010:  st_wmask_c = '1;
                default: st_wmask_c = '0;
            endcase
        end
    end

    // Load lane selection and extension from the latched address.
    always_comb begin : load_format
        case (req_addr_q[1:0])
            2'd0:    ld_byte_c = dmem.dmem_rdata[7:0];
            2'd1:    ld_byte_c = dmem.dmem_rdata[15:8];
            2'd2:    ld_byte_c = dmem.dmem_rdata[23:16];
            default: ld_byte_c = dmem.dmem_rdata[31:24];
        endcase
        ld_half_c = req_addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (req_funct3_q)
            3'b000:  ld_data_c = {{(XLEN-8){ld_byte_c[7]}}, ld_byte_c};
            3'b100:  ld_data_c = {{(XLEN-8){1'b0}}, ld_byte_c};
            3'b001:  ld_data_c = {{(XLEN-16){ld_half_c[15]}}, ld_half_c};
            3'b101:  ld_data_c = {{(XLEN-16){1'b0}}, ld_half_c};
            default: ld_data_c = dmem.dmem_rdata;
        endcase
    end

    always_comb begin : fsm_next
        state_d       = state_q;
        mem_stall     = 1'b0;
        issue_c       = 1'b0;
        wb_valid_d    = 1'b0;
        wb_reg_we_d   = 1'b0;
        wb_rd_d       = wb_rd;
        wb_data_d     = wb_data;
        wb_misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (is_mem_c && !misalign_c) begin
                        issue_c   = 1'b1;
                        mem_stall = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        wb_valid_d    = 1'b1;
                        wb_reg_we_d   = ex_reg_we & ~is_mem_c;
                        wb_rd_d       = ex_rd;
                        wb_data_d     = ex_alu_out;
                        wb_misalign_d = misalign_c;
                    end
                end
            end
            BUSY: begin
                mem_stall = ~dmem.dmem_resp;
                if (dmem.dmem_resp) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_reg_we_d = req_reg_we_q;
                    wb_rd_d     = req_rd_q;
                    wb_data_d   = ld_data_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            req_wmask_q  <= '0;
            req_wdata_q  <= '0;
            req_funct3_q <= '0;
            req_rd_q     <= '0;
            req_reg_we_q <= 1'b0;
            req_load_q   <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_we    <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_misalign  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue_c) begin
                req_addr_q   <= ex_alu_out;
                req_wmask_q  <= st_wmask_c;
                req_wdata_q  <= st_wdata_c;
                req_funct3_q <= ex_funct3;
                req_rd_q     <= ex_rd;
                req_reg_we_q <= ex_reg_we & ex_load;
                req_load_q   <= ex_load;
            end
            wb_valid    <= wb_valid_d;
            wb_reg_we   <= wb_reg_we_d;
            wb_rd       <= wb_rd_d;
            wb_data     <= wb_data_d;
            wb_misalign <= wb_misalign_d;
        end
    end

    assign dmem.dmem_read  = (state_q == BUSY) &&  req_load_q;
    assign dmem.dmem_write = (state_q == BUSY) && !req_load_q;
    assign dmem.dmem_addr  = {req_addr_q[XLEN-1:2], 2'b00};
    assign dmem.dmem_wmask = req_wmask_q;
    assign dmem.dmem_wdata = req_wdata_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table driven back to back, writeback scoreboard with cycle stamps.
module tb_mem_access_stage;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic        load;
        logic        store;
        logic        reg_we;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          delay;
        logic        mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int unsigned cycle;
        logic        reg_we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        misalign;
    } sb_t;

    logic        clk, rst;
    logic        ex_valid, ex_load, ex_store, ex_reg_we;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_out, ex_rs2_data;
    logic        mem_stall, wb_valid, wb_reg_we, wb_misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    sb_t         sb[$];
    vec_t        vecs[17];

    mem_access_stage_if dmem_if ();

    mem_access_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_load     (ex_load),
        .ex_store    (ex_store),
        .ex_reg_we   (ex_reg_we),
        .ex_funct3   (ex_funct3),
        .ex_rd       (ex_rd),
        .ex_alu_out  (ex_alu_out),
        .ex_rs2_data (ex_rs2_data),
        .dmem        (dmem_if),
        .mem_stall   (mem_stall),
        .wb_valid    (wb_valid),
        .wb_reg_we   (wb_reg_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_misalign (wb_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Writeback monitor: wb_valid must rise exactly on the cycle stamped for the oldest entry.
    always @(negedge clk) begin : wb_monitor
        bit  due;
        sb_t e;
        if (mon_en) begin
            due = (sb.size() != 0) && (sb[0].cycle == cyc);
            chk("wb_valid", 32'(wb_valid), 32'(due));
            if (due) begin
                e = sb.pop_front();
                if (wb_valid) begin
                    chk("wb_reg_we", 32'(wb_reg_we), 32'(e.reg_we));
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                    chk("wb_misalign", 32'(wb_misalign), 32'(e.misalign));
                end
            end
        end
    end

    // Drive one op at a negedge; return at the negedge after its writeback edge.
    task automatic drive_op(input vec_t v);
        sb_t e;
        bit  mem, trap;
        int  stalls;
        ex_valid    = 1'b1;
        ex_load     = v.load;
        ex_store    = v.store;
        ex_reg_we   = v.reg_we;
        ex_funct3   = v.f3;
        ex_rd       = v.rd;
        ex_alu_out  = v.alu;
        ex_rs2_data = v.rs2;
        mem  = v.load | v.store;
        trap = TRAP && mem && v.mis;
        e.rd = v.rd;
        e.misalign = 1'b0;
        if (!mem || trap) begin
            e.cycle    = cyc + 1;
            e.reg_we   = trap ? 1'b0 : v.reg_we;
            e.data     = v.alu;
            e.chk_data = 1'b1;
            e.misalign = trap;
            sb.push_back(e);
            #1;
            chk("stall_nomem", 32'(mem_stall), 32'd0);
            chk("req_nomem", 32'({dmem_if.dmem_read, dmem_if.dmem_write}), 32'd0);
            @(negedge clk);
        end else begin
            e.cycle    = cyc + 2 + 32'(v.delay);
            e.reg_we   = v.exp_we;
            e.data     = v.exp_data;
            e.chk_data = v.load;
            sb.push_back(e);
            #1;
            stalls = mem_stall ? 1 : 0;
            for (int d = 0; d <= v.delay; d++) begin
                @(negedge clk);
                dmem_if.dmem_resp  = (d == v.delay);
                dmem_if.dmem_rdata = (d == v.delay) ? v.rdata : $urandom;
                #1;
                chk("dmem_read", 32'(dmem_if.dmem_read), 32'(v.load));
                chk("dmem_write", 32'(dmem_if.dmem_write), 32'(!v.load));
                chk("dmem_addr", dmem_if.dmem_addr, v.exp_addr);
                chk("dmem_wmask", 32'(dmem_if.dmem_wmask), 32'(v.exp_wmask));
                if (!v.load) chk("dmem_wdata", dmem_if.dmem_wdata, v.exp_wdata);
                if (mem_stall) stalls++;
            end
            chk("stall_cycles", 32'(stalls), 32'(v.delay + 1));
            @(negedge clk);
            dmem_if.dmem_resp  = 1'b0;
            dmem_if.dmem_rdata = $urandom;
        end
    endtask

    initial begin
        vec_t v;
        // load store we f3 rd alu rs2 rdata delay mis | addr wmask wdata we data
        vecs[0]  = '{0, 0, 1, 3'b000, 5'd5,  32'h0000_1234, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0000_1234};
        vecs[1]  = '{0, 0, 0, 3'b000, 5'd7,  32'hCAFE_F00D, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'hCAFE_F00D};
        vecs[2]  = '{1, 0, 1, 3'b000, 5'd10, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 3, 0, 32'h100, 4'b0000, 32'h0, 1, 32'hFFFF_FF80};
        vecs[3]  = '{1, 0, 1, 3'b100, 5'd11, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 3, 0, 32'h100, 4'b0000, 32'h0, 1, 32'h0000_0080};
        vecs[4]  = '{1, 0, 1, 3'b000, 5'd12, 32'h0000_0100, 32'h0, 32'h80FF_FF7F, 0, 0, 32'h100, 4'b0000, 32'h0, 1, 32'h0000_007F};
        vecs[5]  = '{1, 0, 1, 3'b001, 5'd13, 32'h0000_0102, 32'h0, 32'h80FF_FF7F, 1, 0, 32'h100, 4'b0000, 32'h0, 1, 32'hFFFF_80FF};
        vecs[6]  = '{1, 0, 1, 3'b101, 5'd14, 32'h0000_0102, 32'h0, 32'h80FF_FF7F, 0, 0, 32'h100, 4'b0000, 32'h0, 1, 32'h0000_80FF};
        vecs[7]  = '{1, 0, 1, 3'b001, 5'd15, 32'h0000_0100, 32'h0, 32'h80FF_FF7F, 0, 0, 32'h100, 4'b0000, 32'h0, 1, 32'hFFFF_FF7F};
        vecs[8]  = '{1, 0, 1, 3'b010, 5'd16, 32'h0000_0200, 32'h0, 32'h1234_5678, 1, 0, 32'h200, 4'b0000, 32'h0, 1, 32'h1234_5678};
        vecs[9]  = '{0, 1, 0, 3'b001, 5'd0,  32'h0000_0202, 32'hDEAD_BEEF, 32'h55AA_55AA, 1, 0, 32'h200, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0};
        vecs[10] = '{0, 1, 1, 3'b000, 5'd9,  32'h0000_0301, 32'h1234_56A5, 32'h0, 2, 0, 32'h300, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0};
        vecs[11] = '{0, 1, 0, 3'b010, 5'd0,  32'h0000_0400, 32'h0102_0304, 32'h0, 0, 0, 32'h400, 4'b1111, 32'h0102_0304, 0, 32'h0};
        vecs[12] = '{1, 0, 1, 3'b011, 5'd17, 32'h0000_0500, 32'h0, 32'h89AB_CDEF, 0, 0, 32'h500, 4'b0000, 32'h0, 1, 32'h89AB_CDEF};
        vecs[13] = '{1, 1, 1, 3'b100, 5'd18, 32'h0000_0102, 32'hFFFF_FFFF, 32'h80FF_FF7F, 1, 0, 32'h100, 4'b0000, 32'h0, 1, 32'h0000_00FF};
        vecs[14] = '{1, 0, 1, 3'b010, 5'd19, 32'h0000_0101, 32'h0, 32'h1122_3344, 0, 1, 32'h100, 4'b0000, 32'h0, 1, 32'h1122_3344};
        vecs[15] = '{0, 1, 0, 3'b001, 5'd0,  32'h0000_0201, 32'h0000_CAFE, 32'h0, 0, 1, 32'h200, 4'b0011, 32'hCAFE_CAFE, 0, 32'h0};
        vecs[16] = '{0, 0, 1, 3'b000, 5'd31, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 32'hFFFF_FFFF};

        rst = 1'b1;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_reg_we = 1'b0;
        ex_funct3 = 3'b000; ex_rd = 5'd0; ex_alu_out = 32'h0; ex_rs2_data = 32'h0;
        dmem_if.dmem_resp = 1'b0;
        dmem_if.dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_reg_we", 32'(wb_reg_we), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_misalign", 32'(wb_misalign), 32'd0);
        chk("rst_req", 32'({dmem_if.dmem_read, dmem_if.dmem_write}), 32'd0);
        chk("rst_wmask", 32'(dmem_if.dmem_wmask), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Table ops issued back to back as the stall releases.
        for (int i = 0; i < 17; i++) drive_op(vecs[i]);
        ex_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Immediate-response lw followed directly by an ALU op.
        v = '{1, 0, 1, 3'b010, 5'd20, 32'h0000_0600, 32'h0, 32'hA5A5_0001, 0, 0, 32'h600, 4'b0000, 32'h0, 1, 32'hA5A5_0001};
        drive_op(v);
        v = '{0, 0, 1, 3'b000, 5'd21, 32'h0000_0077, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0000_0077};
        drive_op(v);
        ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Reset while BUSY with a coincident response.
        mon_en = 1'b0;
        sb.delete();
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_reg_we = 1'b1;
        ex_funct3 = 3'b010; ex_rd = 5'd3; ex_alu_out = 32'h0000_0700;
        @(negedge clk);
        chk("busy_read", 32'(dmem_if.dmem_read), 32'd1);
        rst = 1'b1;
        ex_valid = 1'b0;
        dmem_if.dmem_resp = 1'b1;
        dmem_if.dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("busyrst_read", 32'(dmem_if.dmem_read), 32'd0);
        chk("busyrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("busyrst_stall", 32'(mem_stall), 32'd0);
        rst = 1'b0;
        dmem_if.dmem_resp = 1'b0;
        @(negedge clk);
        chk("postrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("postrst_read", 32'(dmem_if.dmem_read), 32'd0);
        chk("postrst_stall", 32'(mem_stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
